// File: rtl/spi_slave_regfile_if.sv
// SPI pins, commit/status strobes and the local register port of the SPI register file.
// Latency: n/a (signal bundle only).
// Backpressure: none; every signal is a level or a one-cycle strobe.
`timescale 1ns/1ps
interface spi_slave_regfile_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  sclk;
    logic                  cs;
    logic                  mosi;
    logic                  miso;
    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_done;
    logic                  frame_err;
    logic                  lcl_wr_en;
    logic [ADDR_WIDTH-1:0] lcl_addr;
    logic [DATA_WIDTH-1:0] lcl_wdata;
    logic [DATA_WIDTH-1:0] lcl_rdata;

    // The register file side of the bundle.
    modport slave (
        input  sclk, cs, mosi, lcl_wr_en, lcl_addr, lcl_wdata,
        output miso, wr_valid, wr_addr, wr_data, rd_done, frame_err, lcl_rdata
    );

    // The SPI master plus local logic side of the bundle.
    modport master (
        output sclk, cs, mosi, lcl_wr_en, lcl_addr, lcl_wdata,
        input  miso, wr_valid, wr_addr, wr_data, rd_done, frame_err, lcl_rdata
    );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder decoding {rw, addr, data} frames into a register file with a local port.
// Latency: SPI edges act 3 clk after the pin event; write commit 1 clk after the last frame bit.
// Backpressure: none; the SPI master paces everything, local writes land the same cycle.
`timescale 1ns/1ps
module spi_slave_regfile #(
    parameter int ADDR_WIDTH  = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_slave_regfile_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BCW   = $clog2(FRAME_WIDTH + 1);
    localparam int XCW   = $clog2(DATA_WIDTH + 1);
    localparam int TCW   = $clog2(RD_TIMEOUT + 1);

    localparam logic [BCW-1:0] FW_C    = BCW'(FRAME_WIDTH);
    localparam logic [BCW-1:0] FW_LAST = BCW'(FRAME_WIDTH - 1);
    localparam logic [XCW-1:0] DW_LAST = XCW'(DATA_WIDTH - 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RX_CMD, WAIT_RD, TX_DATA} state_t;

    // Synchronizers: [0],[1] are the 2-flop synchronizer, [2] is the edge-detect history.
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;
    logic [1:0] prime_q;
    logic       armed_q;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t                 state_q;
    logic [BCW-1:0]         bit_cnt_q;
    logic [FRAME_WIDTH-1:0] rx_sr_q;
    logic                   dec_q;
    logic [ADDR_WIDTH-1:0]  pend_addr_q;
    logic [DATA_WIDTH-1:0]  tx_sr_q;
    logic [XCW-1:0]         tx_cnt_q;
    logic [TCW-1:0]         to_cnt_q;
    logic                   wr_valid_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic                   rd_done_q;
    logic                   frame_err_q;
    logic [DATA_WIDTH-1:0]  regs_q [DEPTH];

    logic                  rx_rw;
    logic [ADDR_WIDTH-1:0] rx_addr;
    logic [DATA_WIDTH-1:0] rx_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  spi_we;

    assign rx_rw   = rx_sr_q[FRAME_WIDTH-1];
    assign rx_addr = rx_sr_q[DATA_WIDTH +: ADDR_WIDTH];
    assign rx_data = rx_sr_q[DATA_WIDTH-1:0];
    // A read can be closed by cs in the very cycle its frame is decoded, before pend_addr_q updates.
    assign rd_addr = dec_q ? rx_addr : pend_addr_q;
    assign spi_we  = dec_q & rx_rw;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    // cs_fall only counts once cs has really been seen high, so a frame cut by reset is ignored.
    assign cs_fall   = armed_q & ~cs_q[1] & cs_q[2];

    assign bus.miso      = tx_sr_q[DATA_WIDTH-1];
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_done   = rd_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.lcl_rdata = regs_q[bus.lcl_addr];

    // Oversample the SPI pins and arm cs_fall once the synchronizer holds a genuine cs-high sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q  <= 3'b000;
            cs_q    <= 3'b111;
            mosi_q  <= 2'b00;
            prime_q <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[1:0], bus.sclk};
            cs_q    <= {cs_q[1:0], bus.cs};
            mosi_q  <= {mosi_q[0], bus.mosi};
            prime_q <= {prime_q[0], 1'b1};
            if (prime_q[1] && cs_q[1]) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Register file: SPI commit beats a local write to the same address in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (spi_we && rx_addr == ADDR_WIDTH'(i)) begin
                    regs_q[i] <= rx_data;
                end else if (bus.lcl_wr_en && bus.lcl_addr == ADDR_WIDTH'(i)) begin
                    regs_q[i] <= bus.lcl_wdata;
                end
            end
        end
    end

    // Frame FSM: receive, decode, hold a pending read, then shift read data out on miso.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            dec_q       <= 1'b0;
            pend_addr_q <= '0;
            tx_sr_q     <= '0;
            tx_cnt_q    <= '0;
            to_cnt_q    <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_valid_q  <= 1'b0;
            rd_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            dec_q       <= 1'b0;

            if (dec_q) begin
                if (rx_rw) begin
                    wr_valid_q <= 1'b1;
                    wr_addr_q  <= rx_addr;
                    wr_data_q  <= rx_data;
                end else begin
                    pend_addr_q <= rx_addr;
                end
            end

            case (state_q)
                IDLE: begin
                    tx_sr_q <= '0;
                    if (cs_fall) begin
                        state_q   <= RX_CMD;
                        bit_cnt_q <= '0;
                        rx_sr_q   <= '0;
                    end
                end
                RX_CMD: begin
                    if (cs_rise) begin
                        if (bit_cnt_q == FW_C) begin
                            if (rx_rw) begin
                                state_q <= IDLE;
                            end else begin
                                state_q  <= WAIT_RD;
                                tx_sr_q  <= regs_q[rd_addr];
                                to_cnt_q <= '0;
                            end
                        end else begin
                            frame_err_q <= (bit_cnt_q != '0);
                            state_q     <= IDLE;
                        end
                    end else if (sclk_rise && bit_cnt_q != FW_C) begin
                        rx_sr_q   <= {rx_sr_q[FRAME_WIDTH-2:0], mosi_q[1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        dec_q     <= (bit_cnt_q == FW_LAST);
                    end
                end
                WAIT_RD: begin
                    to_cnt_q <= to_cnt_q + 1'b1;
                    if (cs_fall) begin
                        state_q  <= TX_DATA;
                        tx_cnt_q <= '0;
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q <= IDLE;
                        tx_sr_q <= '0;
                    end
                end
                TX_DATA: begin
                    if (cs_rise) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                        tx_sr_q     <= '0;
                    end else if (sclk_rise) begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                        if (tx_cnt_q == DW_LAST) begin
                            rd_done_q <= 1'b1;
                            state_q   <= IDLE;
                            tx_sr_q   <= '0;
                        end
                    end else if (sclk_fall) begin
                        tx_sr_q <= {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
- SPI responder for the team's 100 MHz / 10 MHz SPI master: decodes 12-bit frames {rw, addr[2:0], data[7:0]} into an 8x8 register file and returns read data on miso.
- All SPI inputs are oversampled in the clk domain; there is no sclk-clocked logic.
- Also exposes a local register port so on-chip logic can update or read registers, for example status.

Parameters:
- ADDR_WIDTH, 3, register address width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 8, register and data field width.
- FRAME_WIDTH, 1+ADDR_WIDTH+DATA_WIDTH (12), command frame length in bits.
- RD_TIMEOUT, 255, clk cycles a pending read survives with cs high before it is dropped.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock, idle low (mode 0).
- cs  in  1  chip select; low = frame active, high = idle.
- mosi  in  1  master-to-slave data, MSB first.
- miso  out  1  slave-to-master data, MSB first.
- wr_valid  out  1  one-cycle pulse: an SPI write was committed.
- wr_addr  out  ADDR_WIDTH  address of the committed write.
- wr_data  out  DATA_WIDTH  data of the committed write.
- rd_done  out  1  one-cycle pulse: all read data bits were shifted out.
- frame_err  out  1  one-cycle pulse: cs rose mid-frame.
- lcl_wr_en  in  1  local register write enable.
- lcl_addr  in  ADDR_WIDTH  local write/read address.
- lcl_wdata  in  DATA_WIDTH  local write data.
- lcl_rdata  out  DATA_WIDTH  combinational read of regfile[lcl_addr].

Behaviour:
- Reset and clock: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - Synchronizers for sclk/mosi reset to 0; the cs synchronizer resets to 1.
  - All registers, shift registers and counters reset to 0; FSM resets to IDLE.
  - miso, wr_valid, rd_done and frame_err are 0 in reset.
- Input synchronization:
  - sclk, cs and mosi each pass through 2 flops, plus a third flop for edge detection.
  - sclk_rise, sclk_fall, cs_fall and cs_rise are single-cycle strobes, 3 clk after the pin event.
  - mosi is sampled from its synchronized copy on sclk_rise, so it is aligned with sclk.
- FSM states: IDLE, RX_CMD, WAIT_RD, TX_DATA.
- IDLE:
  - cs_fall -> RX_CMD; bit_cnt and the rx shift register are cleared.
- RX_CMD:
  - Each sclk_rise shifts mosi into the LSB of rx_sr and increments bit_cnt, saturating at FRAME_WIDTH.
  - Rising edges beyond FRAME_WIDTH are ignored.
  - On the sclk_rise that makes bit_cnt == FRAME_WIDTH, the frame is decoded the next cycle.
  - Decode with rw=1: regfile[addr] <= data; wr_valid pulses with wr_addr/wr_data held until the next commit.
  - Decode with rw=0: pending_addr <= addr; the data bits are ignored.
  - cs_rise with bit_cnt == FRAME_WIDTH: rw=1 -> IDLE; rw=0 -> WAIT_RD.
  - cs_rise with bit_cnt of 1..FRAME_WIDTH-1: frame_err pulses, the frame is discarded, -> IDLE.
  - cs_rise with bit_cnt == 0: silently -> IDLE.
- WAIT_RD:
  - On entry, tx_sr <= regfile[pending_addr], so the MSB is on miso before cs falls.
  - The timeout counter increments every cycle.
  - cs_fall -> TX_DATA; tx_cnt is cleared.
  - Timeout counter reaching RD_TIMEOUT -> IDLE with no error pulse.
  - The master's 100-cycle gap is inside this window.
- TX_DATA:
  - miso = tx_sr MSB.
  - sclk_rise increments tx_cnt; sclk_fall shifts tx_sr left by one, filling with 0.
  - The shift lands 2+ clk before the master samples at its next sclk rise.
  - tx_cnt reaching DATA_WIDTH -> rd_done pulse and -> IDLE; cs is not required to have risen.
  - cs_rise before DATA_WIDTH rises -> frame_err pulse, -> IDLE.
- miso is 0 in IDLE and RX_CMD.
- Local port:
  - lcl_wr_en writes regfile[lcl_addr] in the same cycle.
  - If an SPI commit and a local write hit the same address in the same cycle, the SPI write wins; different addresses both write.
  - A local write after the tx_sr load does not alter the read data in flight.
- Reset mid-frame: immediate return to IDLE. Afterwards, a frame already in progress is ignored until the next cs_fall; cs is synchronized as 1 from reset.

Test Plan:
- Write frame 1_101_A5 at 10 MHz -> wr_valid one pulse with wr_addr=5, wr_data=0xA5; afterwards, lcl_addr=5 gives lcl_rdata=0xA5.
- Local write addr 2=0x3C, then master read frame 0_010_xx plus a 100-clk gap plus 8 sclk -> master captures 0x3C MSB first; rd_done pulses once.
- cs raised after 7 bits of a write frame -> frame_err pulse, no wr_valid, regfile unchanged.
- Read command, then cs held high for 300 clk -> no miso activity; the next frame 1_000_FF commits normally.
- SPI write to addr 3=0x11 and local write to addr 3=0x22 in the same cycle -> regfile[3]=0x11. A local write to addr 3 during TX_DATA -> the in-flight byte is unchanged.
- rst_n asserted during TX_DATA bit 4 -> miso=0 and FSM in IDLE. A following write 1_111_5A after a fresh cs_fall commits addr 7=0x5A.
